dds_sched: RTL and testbench
============================

# dds_sched

Time-multiplexed phase-accumulator scheduler for the tracking channels. A single adder is shared across NUM_CHAN per-channel accumulators. On each input sample strobe the block sweeps all channels in ascending order, one per cycle. For each channel it emits the top bits of that channel's phase as that channel's carrier/code NCO output. It sits between the sample front end and the per-channel correlators, and the tracking loops program it through a valid/ready configuration port.

## Interface
- NUM_CHAN, 4: number of channels; ≥2.
- CHAN_WIDTH, 2: channel index width; equals clog2(NUM_CHAN).
- ACC_WIDTH, 32: accumulator width.
- PHASE_INC_WIDTH, 30: increment width; ≤ ACC_WIDTH; zero-extended into the adder.
- OUTPUT_WIDTH, 3: phase bits output; taken from the accumulator MSBs.

- clk  in  1  sole clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- sample_valid  in  1  one-cycle strobe requesting a sweep.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  tied to 1 after reset; 0 while reset is asserted.
- cfg_chan  in  CHAN_WIDTH  target channel.
- cfg_inc  in  PHASE_INC_WIDTH  new phase increment.
- cfg_enable  in  1  channel enable.
- cfg_clear  in  1  zero the channel accumulator at its next slot.
- busy  out  1  sweep in progress.
- out_valid  out  1  slot result valid.
- out_chan  out  CHAN_WIDTH  channel of the current result.
- out_phase  out  OUTPUT_WIDTH  accumulator[ACC_WIDTH-1 -: OUTPUT_WIDTH] after the update.
- overrun  out  1  sticky dropped-sample flag.
- overrun_clr  in  1  clears overrun.

## Operation
- FSM states IDLE and SWEEP.
  - IDLE → SWEEP when sample_valid=1. On that edge the slot counter is set to 0 and all shadow registers are copied to the active registers atomically.
  - SWEEP → IDLE after the slot with counter NUM_CHAN-1.
- Configuration writes complete on cfg_valid & cfg_ready.
  - Each write updates the shadow inc, enable and clear_pend for cfg_chan.
  - A write never alters the active values mid-sweep.
  - A write in the same cycle as sweep acceptance lands in the shadow after the copy, so it takes effect at the following sweep.
  - cfg_clear=1 sets clear_pend. It is consumed (cleared) by the shadow→active copy that transfers it.
- Slot k update:
  - If active clear: acc[k] ← 0.
  - Else if active enable: acc[k] ← acc[k] + zero-extended inc.
  - Else acc[k] is held.
  - Addition is modulo 2^ACC_WIDTH; wrap-around is silent.
- Disabled channels still produce an out_valid slot carrying their held phase.
- A sample_valid arriving while in SWEEP is dropped. It never restarts or extends the sweep.

## Timing
- Reset values:
  - all outputs 0
  - FSM in IDLE
  - all accumulators 0
  - all shadow/active inc 0, enable 0, clear_pend 0
- sample_valid accepted at edge T (in IDLE) → busy=1 during cycles T+1 … T+NUM_CHAN.
- out_valid=1 in the same cycles, with out_chan = 0 … NUM_CHAN-1 ascending.
- out_phase and out_chan are registered and change only with out_valid.
- Minimum sample spacing is NUM_CHAN+1 cycles.
  - sample_valid on the cycle busy falls (back in IDLE) is accepted.
  - sample_valid in any earlier busy cycle is dropped.
- overrun_clr and a new overrun in the same cycle: overrun stays set; set wins.
- Reset asserted mid-sweep: immediate return to reset state. The partial sweep is lost and no further out_valid is emitted.

## Configuration
- DDS_SCHED_OVERRUN_EN defined: overrun sets on any dropped sample_valid and clears on overrun_clr.
- Not defined: overrun is constant 0, overrun_clr is ignored, and the detection logic is absent. Dropping behaviour is unchanged.

## Structure
- Package dds_sched_pkg holds:
  - state enum {IDLE, SWEEP}
  - default parameter constants
  - clog2 helper
- Sub-module dds_sched_acc_bank: NUM_CHAN×ACC_WIDTH accumulator array with a single shared adder.
  - Inputs: slot index, inc, enable, clear.
  - Output: MSB slice of the updated value.
- The top level holds the FSM, slot counter, shadow/active registers, config port and overrun logic.

## Test plan
- Reset, no config; one sample_valid → 4 out_valid cycles, out_chan 0,1,2,3, every out_phase 0.
- ch1 configured with inc=0x2000_0000 and enable=1; 8 sweeps → ch1 out_phase 1,2,…,7,0 (wrap), other channels stay 0.
- cfg write to ch2 (inc=0x1000_0000) in the same cycle as sweep acceptance → ch2 unchanged in that sweep, increments from the next sweep.
- ch1 running; cfg_clear=1 to ch1 → ch1 reports 0 at its next slot, then resumes incrementing.
- sample_valid pulses 2 cycles apart → second is dropped, only 4 out_valid. With DDS_SCHED_OVERRUN_EN, overrun=1 until overrun_clr; without it, overrun stays 0.
- Reset pulled low while out_chan=2 → all outputs 0 immediately, accumulators 0, no further out_valid.

Source files
------------

// File: rtl/dds_sched_pkg.sv
// Shared types and defaults for the dds_sched phase-accumulator scheduler.
// Holds the sweep state enum, default parameter values and a clog2 helper.
package dds_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    localparam int DEF_NUM_CHAN        = 4;
    localparam int DEF_ACC_WIDTH       = 32;
    localparam int DEF_PHASE_INC_WIDTH = 30;
    localparam int DEF_OUTPUT_WIDTH    = 3;

    // Bounded loop so the helper elaborates cleanly as a constant function.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int DEF_CHAN_WIDTH = clog2(DEF_NUM_CHAN);

endpackage

// File: rtl/dds_sched_acc_bank.sv
// Per-channel phase accumulator array sharing a single adder.
// One slot is updated per enabled cycle; the MSB slice of the new value is returned.
module dds_sched_acc_bank
    import dds_sched_pkg::*;
#(
    parameter int NUM_CHAN        = DEF_NUM_CHAN,
    parameter int CHAN_WIDTH      = clog2(NUM_CHAN),
    parameter int ACC_WIDTH       = DEF_ACC_WIDTH,
    parameter int PHASE_INC_WIDTH = DEF_PHASE_INC_WIDTH,
    parameter int OUTPUT_WIDTH    = DEF_OUTPUT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       update_i,
    input  logic [CHAN_WIDTH-1:0]      slot_i,
    input  logic [PHASE_INC_WIDTH-1:0] inc_i,
    input  logic                       enable_i,
    input  logic                       clear_i,
    output logic [OUTPUT_WIDTH-1:0]    phase_o
);

    logic [ACC_WIDTH-1:0] acc_q [NUM_CHAN];
    logic [ACC_WIDTH-1:0] accSel;
    logic [ACC_WIDTH-1:0] accNew;

    // Clear has priority over accumulation; a disabled channel just holds.
    always_comb begin
        accSel = acc_q[slot_i];
        accNew = accSel;
        if (clear_i) begin
            accNew = '0;
        end else if (enable_i) begin
            accNew = accSel + ACC_WIDTH'(inc_i);
        end
    end

    assign phase_o = accNew[ACC_WIDTH-1 -: OUTPUT_WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                acc_q[i] <= '0;
            end
        end else if (update_i) begin
            acc_q[slot_i] <= accNew;
        end
    end

endmodule

// File: rtl/dds_sched.sv
// Time-multiplexed DDS scheduler: sweeps all channel accumulators once per sample strobe.
// Optional sticky overrun detection is built only when DDS_SCHED_OVERRUN_EN is defined.
module dds_sched
    import dds_sched_pkg::*;
#(
    parameter int NUM_CHAN        = DEF_NUM_CHAN,
    parameter int CHAN_WIDTH      = clog2(NUM_CHAN),
    parameter int ACC_WIDTH       = DEF_ACC_WIDTH,
    parameter int PHASE_INC_WIDTH = DEF_PHASE_INC_WIDTH,
    parameter int OUTPUT_WIDTH    = DEF_OUTPUT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_valid,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [CHAN_WIDTH-1:0]      cfg_chan,
    input  logic [PHASE_INC_WIDTH-1:0] cfg_inc,
    input  logic                       cfg_enable,
    input  logic                       cfg_clear,
    output logic                       busy,
    output logic                       out_valid,
    output logic [CHAN_WIDTH-1:0]      out_chan,
    output logic [OUTPUT_WIDTH-1:0]    out_phase,
    output logic                       overrun,
    input  logic                       overrun_clr
);

    localparam logic [CHAN_WIDTH-1:0] LAST_SLOT = CHAN_WIDTH'(NUM_CHAN - 1);

    state_e                    state_q;
    logic [CHAN_WIDTH-1:0]     slot_q;
    logic                      busy_q;
    logic                      outValid_q;
    logic [CHAN_WIDTH-1:0]     outChan_q;
    logic [OUTPUT_WIDTH-1:0]   outPhase_q;
    logic                      cfgReady_q;

    logic [PHASE_INC_WIDTH-1:0] shadowInc_q [NUM_CHAN];
    logic [PHASE_INC_WIDTH-1:0] shadowInc_d [NUM_CHAN];
    logic [NUM_CHAN-1:0]        shadowEn_q;
    logic [NUM_CHAN-1:0]        shadowEn_d;
    logic [NUM_CHAN-1:0]        shadowClr_q;
    logic [NUM_CHAN-1:0]        shadowClr_d;
    logic [PHASE_INC_WIDTH-1:0] activeInc_q [NUM_CHAN];
    logic [NUM_CHAN-1:0]        activeEn_q;
    logic [NUM_CHAN-1:0]        activeClr_q;

    logic                       accept;
    logic                       advance;
    logic                       cfgWrite;
    logic [CHAN_WIDTH-1:0]      nextSlot;
    logic                       update;
    logic [CHAN_WIDTH-1:0]      updSlot;
    logic [PHASE_INC_WIDTH-1:0] updInc;
    logic                       updEn;
    logic                       updClr;
    logic [OUTPUT_WIDTH-1:0]    bankPhase;

    assign accept   = (state_q == IDLE) && sample_valid;
    assign advance  = (state_q == SWEEP) && (slot_q != LAST_SLOT);
    assign cfgWrite = cfg_valid && cfgReady_q;
    assign nextSlot = slot_q + CHAN_WIDTH'(1);
    assign update   = accept || advance;

    // Slot 0 is computed on the acceptance edge itself, so it reads the shadow
    // values that are being copied into the active set on that same edge.
    always_comb begin
        updSlot = nextSlot;
        updInc  = activeInc_q[nextSlot];
        updEn   = activeEn_q[nextSlot];
        updClr  = activeClr_q[nextSlot];
        if (accept) begin
            updSlot = '0;
            updInc  = shadowInc_q[0];
            updEn   = shadowEn_q[0];
            updClr  = shadowClr_q[0];
        end
    end

    // Pending clears are consumed by the copy, then a coincident write lands on top.
    always_comb begin
        shadowInc_d = shadowInc_q;
        shadowEn_d  = shadowEn_q;
        shadowClr_d = shadowClr_q;
        if (accept) begin
            shadowClr_d = '0;
        end
        if (cfgWrite) begin
            shadowInc_d[cfg_chan] = cfg_inc;
            shadowEn_d[cfg_chan]  = cfg_enable;
            if (cfg_clear) begin
                shadowClr_d[cfg_chan] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                shadowInc_q[i] <= '0;
                activeInc_q[i] <= '0;
            end
            shadowEn_q  <= '0;
            shadowClr_q <= '0;
            activeEn_q  <= '0;
            activeClr_q <= '0;
        end else begin
            shadowInc_q <= shadowInc_d;
            shadowEn_q  <= shadowEn_d;
            shadowClr_q <= shadowClr_d;
            if (accept) begin
                activeInc_q <= shadowInc_q;
                activeEn_q  <= shadowEn_q;
                activeClr_q <= shadowClr_q;
            end
        end
    end

    // Sweep FSM with registered outputs; the displayed slot tracks the counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            busy_q     <= 1'b0;
            outValid_q <= 1'b0;
            outChan_q  <= '0;
            outPhase_q <= '0;
            cfgReady_q <= 1'b0;
        end else begin
            cfgReady_q <= 1'b1;
            if (update) begin
                outPhase_q <= bankPhase;
            end
            case (state_q)
                IDLE: begin
                    if (sample_valid) begin
                        state_q    <= SWEEP;
                        slot_q     <= '0;
                        busy_q     <= 1'b1;
                        outValid_q <= 1'b1;
                        outChan_q  <= '0;
                    end else begin
                        busy_q     <= 1'b0;
                        outValid_q <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (slot_q == LAST_SLOT) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        outValid_q <= 1'b0;
                    end else begin
                        slot_q     <= nextSlot;
                        busy_q     <= 1'b1;
                        outValid_q <= 1'b1;
                        outChan_q  <= nextSlot;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    dds_sched_acc_bank #(
        .NUM_CHAN        (NUM_CHAN),
        .CHAN_WIDTH      (CHAN_WIDTH),
        .ACC_WIDTH       (ACC_WIDTH),
        .PHASE_INC_WIDTH (PHASE_INC_WIDTH),
        .OUTPUT_WIDTH    (OUTPUT_WIDTH)
    ) uAccBank (
        .clk      (clk),
        .reset    (reset),
        .update_i (update),
        .slot_i   (updSlot),
        .inc_i    (updInc),
        .enable_i (updEn),
        .clear_i  (updClr),
        .phase_o  (bankPhase)
    );

`ifdef DDS_SCHED_OVERRUN_EN
    logic overrun_q;

    // A drop in the same cycle as a clear request keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else if ((state_q == SWEEP) && sample_valid) begin
            overrun_q <= 1'b1;
        end else if (overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun = overrun_q;
`else
    logic unusedOverrunClr;
    assign unusedOverrunClr = overrun_clr;
    assign overrun          = 1'b0;
`endif

    assign cfg_ready = cfgReady_q;
    assign busy      = busy_q;
    assign out_valid = outValid_q;
    assign out_chan  = outChan_q;
    assign out_phase = outPhase_q;

endmodule

// File: tb/tb_dds_sched.sv
// Self-checking bench for dds_sched: table of sweeps, hand-written corner cases,
// then randomized traffic compared every cycle against a sweep-level reference model.
module tb_dds_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_chan = '0;
    logic [29:0] cfg_inc = '0;
    logic        cfg_enable = 1'b0;
    logic        cfg_clear = 1'b0;
    logic        busy;
    logic        out_valid;
    logic [1:0]  out_chan;
    logic [2:0]  out_phase;
    logic        overrun;
    logic        overrun_clr = 1'b0;

    int checkCount = 0;
    int passCount  = 0;

    dds_sched dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_chan     (cfg_chan),
        .cfg_inc      (cfg_inc),
        .cfg_enable   (cfg_enable),
        .cfg_clear    (cfg_clear),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_chan     (out_chan),
        .out_phase    (out_phase),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a whole sweep is evaluated at once on acceptance, and the
    // per-cycle outputs are then replayed from the stored results.
    logic [31:0] mAcc [4];
    logic [29:0] mInc [4];
    logic        mEn  [4];
    logic        mClr [4];
    logic [2:0]  mRes [4];
    int          mLeft;
    logic [1:0]  mChan;
    logic [2:0]  mPhase;
    logic        mOverrun;
    logic        mReady;
    logic        mWasBusy;
    logic        mWrite;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                mAcc[i] = '0; mInc[i] = '0; mEn[i] = 1'b0; mClr[i] = 1'b0; mRes[i] = '0;
            end
            mLeft = 0; mChan = '0; mPhase = '0; mOverrun = 1'b0; mReady = 1'b0;
        end else begin
            mWasBusy = (mLeft > 0);
            mWrite   = cfg_valid && mReady;
            if (mWasBusy) mLeft = mLeft - 1;
`ifdef DDS_SCHED_OVERRUN_EN
            if (sample_valid && mWasBusy) mOverrun = 1'b1;
            else if (overrun_clr) mOverrun = 1'b0;
`endif
            if (!mWasBusy && sample_valid) begin
                for (int k = 0; k < 4; k++) begin
                    if (mClr[k]) mAcc[k] = '0;
                    else if (mEn[k]) mAcc[k] = mAcc[k] + {2'b00, mInc[k]};
                    mRes[k] = mAcc[k][31:29];
                    mClr[k] = 1'b0;
                end
                mLeft = 4;
            end
            if (mLeft > 0) begin
                mChan  = 2'(4 - mLeft);
                mPhase = mRes[4 - mLeft];
            end
            if (mWrite) begin
                mInc[cfg_chan] = cfg_inc;
                mEn[cfg_chan]  = cfg_enable;
                if (cfg_clear) mClr[cfg_chan] = 1'b1;
            end
            mReady = 1'b1;
        end
    end

    logic checkEn = 1'b0;
    logic countEn = 1'b0;
    int   validCount = 0;

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model busy", busy, mLeft > 0);
            checkOutput("model out_valid", out_valid, mLeft > 0);
            checkOutput("model out_chan", out_chan, mChan);
            checkOutput("model out_phase", out_phase, mPhase);
            checkOutput("model overrun", overrun, mOverrun);
            checkOutput("model cfg_ready", cfg_ready, mReady);
        end
        if (countEn) validCount += out_valid;
    end

    typedef struct packed {
        logic            doCfg;
        logic [1:0]      chan;
        logic [29:0]     inc;
        logic            en;
        logic            clr;
        logic [3:0][2:0] expPhase;
    } vec_t;

    vec_t vecs [12];

    task automatic setVec(input int i, input logic doCfg, input logic [1:0] chan,
                          input logic [29:0] inc, input logic en, input logic clr,
                          input logic [2:0] e0, input logic [2:0] e1,
                          input logic [2:0] e2, input logic [2:0] e3);
        vecs[i].doCfg    = doCfg;
        vecs[i].chan     = chan;
        vecs[i].inc      = inc;
        vecs[i].en       = en;
        vecs[i].clr      = clr;
        vecs[i].expPhase = {e3, e2, e1, e0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfgWrite(input logic [1:0] chan, input logic [29:0] inc,
                            input logic en, input logic clr);
        cfg_valid = 1'b1; cfg_chan = chan; cfg_inc = inc; cfg_enable = en; cfg_clear = clr;
        tick();
        cfg_valid = 1'b0; cfg_clear = 1'b0;
    endtask

    task automatic runSweep(input logic [3:0][2:0] exp);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("table out_valid", out_valid, 1);
            checkOutput("table out_chan", out_chan, k);
            checkOutput("table out_phase", out_phase, exp[k]);
            tick();
        end
        @(negedge clk);
        checkOutput("table busy after sweep", busy, 0);
        tick();
    endtask

    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            sample_valid = ($urandom_range(0, 3) == 0);
            cfg_valid    = ($urandom_range(0, 2) == 0);
            cfg_chan     = 2'($urandom_range(0, 3));
            cfg_inc      = 30'($urandom());
            cfg_enable   = ($urandom_range(0, 3) != 0);
            cfg_clear    = ($urandom_range(0, 7) == 0);
            overrun_clr  = ($urandom_range(0, 9) == 0);
            tick();
        end
        sample_valid = 1'b0; cfg_valid = 1'b0; cfg_clear = 1'b0; overrun_clr = 1'b0;
    endtask

    logic expOv;

    initial begin
`ifdef DDS_SCHED_OVERRUN_EN
        expOv = 1'b1;
`else
        expOv = 1'b0;
`endif
        setVec(0,  1'b0, 2'd0, 30'h0,         1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        setVec(1,  1'b1, 2'd1, 30'h2000_0000, 1'b1, 1'b0, 3'd0, 3'd1, 3'd0, 3'd0);
        setVec(2,  1'b0, 2'd0, 30'h0,         1'b0, 1'b0, 3'd0, 3'd2, 3'd0, 3'd0);
        setVec(3,  1'b0, 2'd0, 30'h0,         1'b0, 1'b0, 3'd0, 3'd3, 3'd0, 3'd0);
        setVec(4,  1'b0, 2'd0, 30'h0,         1'b0, 1'b0, 3'd0, 3'd4, 3'd0, 3'd0);
        setVec(5,  1'b0, 2'd0, 30'h0,         1'b0, 1'b0, 3'd0, 3'd5, 3'd0, 3'd0);
        setVec(6,  1'b0, 2'd0, 30'h0,         1'b0, 1'b0, 3'd0, 3'd6, 3'd0, 3'd0);
        setVec(7,  1'b0, 2'd0, 30'h0,         1'b0, 1'b0, 3'd0, 3'd7, 3'd0, 3'd0);
        setVec(8,  1'b0, 2'd0, 30'h0,         1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        setVec(9,  1'b0, 2'd0, 30'h0,         1'b0, 1'b0, 3'd0, 3'd1, 3'd0, 3'd0);
        setVec(10, 1'b1, 2'd1, 30'h2000_0000, 1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0);
        setVec(11, 1'b0, 2'd0, 30'h0,         1'b0, 1'b0, 3'd0, 3'd1, 3'd0, 3'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_chan", out_chan, 0);
        checkOutput("reset out_phase", out_phase, 0);
        checkOutput("reset overrun", overrun, 0);
        checkOutput("reset cfg_ready", cfg_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        checkOutput("cfg_ready after reset", cfg_ready, 1);
        checkEn = 1'b1;

        // Table of sweeps: idle channels, ch1 counting through wrap, then clear
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].doCfg) begin
                cfgWrite(vecs[i].chan, vecs[i].inc, vecs[i].en, vecs[i].clr);
                tick();
            end
            runSweep(vecs[i].expPhase);
        end

        // Sample held for six edges: accepted on the first and on the sixth only
        validCount = 0;
        countEn = 1'b1;
        sample_valid = 1'b1;
        repeat (6) tick();
        sample_valid = 1'b0;
        repeat (8) tick();
        countEn = 1'b0;
        checkOutput("held sample out_valid count", validCount, 8);
        checkOutput("overrun after drops", overrun, expOv);

        // Pulses two cycles apart: second dropped
        validCount = 0;
        countEn = 1'b1;
        sample_valid = 1'b1; tick();
        sample_valid = 1'b0; tick();
        sample_valid = 1'b1; tick();
        sample_valid = 1'b0;
        repeat (8) tick();
        countEn = 1'b0;
        checkOutput("two-apart out_valid count", validCount, 4);
        checkOutput("overrun before clear", overrun, expOv);
        overrun_clr = 1'b1; tick();
        overrun_clr = 1'b0;
        checkOutput("overrun after clear", overrun, 0);

        // Reset pulled low while channel 2 is displayed
        sample_valid = 1'b1; tick();
        sample_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        checkOutput("pre-reset out_chan", out_chan, 2);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid reset out_valid", out_valid, 0);
        checkOutput("mid reset busy", busy, 0);
        checkOutput("mid reset out_chan", out_chan, 0);
        checkOutput("mid reset out_phase", out_phase, 0);
        checkOutput("mid reset cfg_ready", cfg_ready, 0);
        validCount = 0;
        countEn = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (5) tick();
        countEn = 1'b0;
        checkOutput("no out_valid after reset", validCount, 0);
        runSweep({3'd0, 3'd0, 3'd0, 3'd0});

        // Config write coincident with sweep acceptance takes effect one sweep later
        cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_inc = 30'h1000_0000; cfg_enable = 1'b1;
        runSweep({3'd0, 3'd0, 3'd0, 3'd0});
        cfg_valid = 1'b0;
        runSweep({3'd0, 3'd0, 3'd0, 3'd0});
        runSweep({3'd0, 3'd1, 3'd0, 3'd0});

        // Randomized traffic checked against the model every cycle
        applyStimulus(3000);
        repeat (6) tick();

        checkEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
